// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate and retire, multi-port write-back,
// operand lookup with same-cycle bypass, LSB store handshake and registered redirect.
module rob_param #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int XLEN   = 32,
  parameter int NUM_WB = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    alloc_valid,
  input  logic [2:0]              alloc_kind,
  input  logic [4:0]              alloc_rd,
  input  logic                    alloc_pred_taken,
  input  logic [XLEN-1:0]         alloc_aux,
  output logic                    alloc_ready,
  output logic [IDX_W-1:0]        alloc_idx,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] wb_idx,
  input  logic [NUM_WB*XLEN-1:0]  wb_val,
  input  logic [IDX_W-1:0]        rs1_idx,
  input  logic [IDX_W-1:0]        rs2_idx,
  output logic                    rs1_ready,
  output logic                    rs2_ready,
  output logic [XLEN-1:0]         rs1_val,
  output logic [XLEN-1:0]         rs2_val,
  output logic                    commit_valid,
  output logic [IDX_W-1:0]        commit_idx,
  output logic [4:0]              commit_rd,
  output logic [XLEN-1:0]         commit_val,
  output logic                    commit_store,
  input  logic                    store_ack,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc,
  output logic [IDX_W:0]          count
);

  localparam logic [2:0] K_ALU    = 3'd0;
  localparam logic [2:0] K_LOAD   = 3'd1;
  localparam logic [2:0] K_STORE  = 3'd2;
  localparam logic [2:0] K_BRANCH = 3'd3;
  localparam logic [2:0] K_JALR   = 3'd4;
  localparam logic [2:0] K_DIRECT = 3'd5;
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  // An index is live when its distance from head is below the occupancy.
  function automatic logic f_in_window(input logic [IDX_W-1:0] idx,
                                       input logic [IDX_W-1:0] head,
                                       input logic [IDX_W:0]   cnt);
    logic [IDX_W-1:0] off;
    off = idx - head;
    return ({1'b0, off} < cnt);
  endfunction

  logic [2:0]       r_kind  [DEPTH];
  logic [4:0]       r_rd    [DEPTH];
  logic [XLEN-1:0]  r_aux   [DEPTH];
  logic [XLEN-1:0]  r_val   [DEPTH];
  logic [DEPTH-1:0] r_pred;
  logic [DEPTH-1:0] r_taken;
  logic [DEPTH-1:0] r_ready;
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_count;
  logic             r_redirect_valid;
  logic [XLEN-1:0]  r_redirect_pc;

  logic [IDX_W-1:0] w_wb_idx  [NUM_WB];
  logic [XLEN-1:0]  w_wb_val  [NUM_WB];
  logic [NUM_WB-1:0] w_wb_ok;
  logic [DEPTH-1:0] w_byp_hit;
  logic [XLEN-1:0]  w_byp_val [DEPTH];
  logic [IDX_W-1:0] w_rs_idx  [2];
  logic             w_rs_ready [2];
  logic [XLEN-1:0]  w_rs_val  [2];

  logic [2:0] w_head_kind;
  logic       w_nonempty;
  logic       w_head_store;
  logic       w_head_branch;
  logic       w_head_jalr;
  logic       w_head_done;
  logic       w_flush;
  logic       w_alloc_ready;
  logic       w_alloc;

  genvar gp;
  generate
    for (gp = 0; gp < NUM_WB; gp++) begin : g_wb
      assign w_wb_idx[gp] = wb_idx[gp*IDX_W +: IDX_W];
      assign w_wb_val[gp] = wb_val[gp*XLEN +: XLEN];
      assign w_wb_ok[gp]  = rdy & wb_valid[gp] & f_in_window(w_wb_idx[gp], r_head, r_count);
    end
  endgenerate

  // Per-entry write-back this cycle; iterating downwards lets the lowest port win.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_byp_hit[e] = 1'b0;
      w_byp_val[e] = '0;
      for (int p = NUM_WB - 1; p >= 0; p--) begin
        w_byp_val[e] = (w_wb_ok[p] && (w_wb_idx[p] == IDX_W'(e))) ? w_wb_val[p] : w_byp_val[e];
        w_byp_hit[e] = w_byp_hit[e] | (w_wb_ok[p] && (w_wb_idx[p] == IDX_W'(e)));
      end
    end
  end

  assign w_head_kind   = r_kind[r_head];
  assign w_nonempty    = (r_count != '0);
  assign w_head_store  = (w_head_kind == K_STORE);
  assign w_head_branch = (w_head_kind == K_BRANCH);
  assign w_head_jalr   = (w_head_kind == K_JALR);
  assign w_head_done   = rdy & w_nonempty & (w_head_store ? store_ack : r_ready[r_head]);
  assign w_flush       = w_head_done &
                         ((w_head_branch & (r_taken[r_head] != r_pred[r_head])) | w_head_jalr);
  assign w_alloc_ready = rdy & (r_count != FULL_CNT) & ~r_redirect_valid;
  assign w_alloc       = alloc_valid & w_alloc_ready;

  assign w_rs_idx[0] = rs1_idx;
  assign w_rs_idx[1] = rs2_idx;

  // Operand lookup: stored value, else same-cycle bypass, else the tag itself.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      if ((r_kind[w_rs_idx[s]] == K_BRANCH) || (r_kind[w_rs_idx[s]] == K_STORE)) begin
        w_rs_ready[s] = 1'b1;
        w_rs_val[s]   = '0;
      end else if (r_ready[w_rs_idx[s]]) begin
        w_rs_ready[s] = 1'b1;
        w_rs_val[s]   = r_val[w_rs_idx[s]];
      end else if (w_byp_hit[w_rs_idx[s]]) begin
        // A JALR write-back carries the target; the operand is still the link.
        w_rs_ready[s] = 1'b1;
        w_rs_val[s]   = (r_kind[w_rs_idx[s]] == K_JALR) ? r_val[w_rs_idx[s]]
                                                         : w_byp_val[w_rs_idx[s]];
      end else begin
        w_rs_ready[s] = 1'b0;
        w_rs_val[s]   = XLEN'(w_rs_idx[s]);
      end
    end
  end

  assign rs1_ready      = w_rs_ready[0];
  assign rs1_val        = w_rs_val[0];
  assign rs2_ready      = w_rs_ready[1];
  assign rs2_val        = w_rs_val[1];
  assign alloc_ready    = w_alloc_ready;
  assign alloc_idx      = r_tail;
  assign commit_valid   = w_head_done & ~w_head_store & ~w_head_branch & (r_rd[r_head] != 5'd0);
  assign commit_idx     = r_head;
  assign commit_rd      = r_rd[r_head];
  assign commit_val     = r_val[r_head];
  assign commit_store   = rdy & w_nonempty & w_head_store;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign count          = r_count;

  // Entry storage: allocation at tail, write-back updates, flush drops all ready bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ready <= '0;
    end else if (rdy) begin
      if (w_flush) begin
        r_ready <= '0;
      end else begin
        for (int e = 0; e < DEPTH; e++) begin
          if (w_alloc && (r_tail == IDX_W'(e))) begin
            r_kind[e]  <= alloc_kind;
            r_rd[e]    <= alloc_rd;
            r_pred[e]  <= alloc_pred_taken;
            r_taken[e] <= 1'b0;
            r_aux[e]   <= alloc_aux;
            r_val[e]   <= ((alloc_kind == K_JALR) || (alloc_kind == K_DIRECT)) ? alloc_aux : '0;
            r_ready[e] <= (alloc_kind == K_STORE) || (alloc_kind == K_DIRECT);
          end else if (w_byp_hit[e]) begin
            r_ready[e] <= 1'b1;
            case (r_kind[e])
              K_ALU, K_LOAD: r_val[e]   <= w_byp_val[e];
              K_BRANCH:      r_taken[e] <= w_byp_val[e][0];
              K_JALR:        r_aux[e]   <= w_byp_val[e];
              default:       r_taken[e] <= r_taken[e];
            endcase
          end
        end
      end
    end
  end

  // Pointers, occupancy and the one-cycle redirect pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else if (rdy) begin
      r_redirect_valid <= w_flush;
      if (w_flush) begin
        r_head        <= '0;
        r_tail        <= '0;
        r_count       <= '0;
        r_redirect_pc <= r_aux[r_head];
      end else begin
        if (w_head_done) begin
          r_head <= r_head + IDX_W'(1);
        end
        if (w_alloc) begin
          r_tail <= r_tail + IDX_W'(1);
        end
        case ({w_alloc, w_head_done})
          2'b10:   r_count <= r_count + (IDX_W+1)'(1);
          2'b01:   r_count <= r_count - (IDX_W+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Self-checking bench for rob_param (DEPTH=4): directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_rob_param;
  localparam int DEPTH = 4;
  localparam int IDX_W = 2;
  localparam int XLEN = 32;
  localparam int NUM_WB = 2;

  logic clk = 1'b0;
  logic rst, rdy, alloc_valid, alloc_pred_taken, alloc_ready, store_ack;
  logic [2:0] alloc_kind;
  logic [4:0] alloc_rd, commit_rd;
  logic [XLEN-1:0] alloc_aux, rs1_val, rs2_val, commit_val, redirect_pc;
  logic [IDX_W-1:0] alloc_idx, rs1_idx, rs2_idx, commit_idx;
  logic [NUM_WB-1:0] wb_valid;
  logic [NUM_WB*IDX_W-1:0] wb_idx;
  logic [NUM_WB*XLEN-1:0] wb_val;
  logic rs1_ready, rs2_ready, commit_valid, commit_store, redirect_valid;
  logic [IDX_W:0] count;

  int checks = 0;
  int errors = 0;

  rob_param #(.DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN), .NUM_WB(NUM_WB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_kind(alloc_kind), .alloc_rd(alloc_rd),
    .alloc_pred_taken(alloc_pred_taken), .alloc_aux(alloc_aux),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_val(wb_val),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .commit_valid(commit_valid), .commit_idx(commit_idx), .commit_rd(commit_rd),
    .commit_val(commit_val), .commit_store(commit_store), .store_ack(store_ack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: the buffer as a program-ordered queue.
  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic        pred;
    logic [31:0] aux;
    logic [31:0] val;
    logic [31:0] tgt;
    logic        taken;
    logic        rdy;
  } ent_t;
  ent_t q[$];
  int m_head;
  bit m_redir;
  logic [31:0] m_redir_pc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0; alloc_kind = 3'd0; alloc_rd = 5'd0; alloc_pred_taken = 1'b0;
    alloc_aux = '0; wb_valid = '0; wb_idx = '0; wb_val = '0; store_ack = 1'b0;
    rs1_idx = '0; rs2_idx = '0;
  endtask

  task automatic do_reset();
    idle();
    rdy = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic alloc(input logic [2:0] k, input logic [4:0] rd, input logic pred, input logic [31:0] aux);
    alloc_valid = 1'b1; alloc_kind = k; alloc_rd = rd; alloc_pred_taken = pred; alloc_aux = aux;
    tick();
    alloc_valid = 1'b0;
    #1;
  endtask

  task automatic wb0(input logic [1:0] idx, input logic [31:0] v);
    wb_valid = 2'b01; wb_idx = {2'b00, idx}; wb_val = {32'h0, v};
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %0b want 1", alloc_ready); end
    checks++; if (alloc_idx !== 2'd0) begin errors++; $display("FAIL reset_alloc_idx got %0d want 0", alloc_idx); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (commit_valid !== 1'b0 || commit_store !== 1'b0) begin errors++; $display("FAIL reset_commit got %0b/%0b want 0/0", commit_valid, commit_store); end
    checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect got %0b/%h want 0/0", redirect_valid, redirect_pc); end
  endtask

  task automatic test_bypass_commit();
    do_reset();
    alloc(3'd0, 5'd5, 1'b0, 32'h0);
    rs1_idx = 2'd0; #1;
    checks++; if (rs1_ready !== 1'b0 || rs1_val !== 32'h0) begin errors++; $display("FAIL lookup_pending got %0b/%h want 0/0", rs1_ready, rs1_val); end
    wb0(2'd0, 32'h1234); #1;
    checks++; if (rs1_ready !== 1'b1 || rs1_val !== 32'h1234) begin errors++; $display("FAIL lookup_bypass got %0b/%h want 1/1234", rs1_ready, rs1_val); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL wb_same_cycle_commit got %0b want 0", commit_valid); end
    tick(); wb_valid = '0; #1;
    checks++; if (commit_valid !== 1'b1 || commit_rd !== 5'd5 || commit_val !== 32'h1234) begin errors++; $display("FAIL alu_commit got %0b/%0d/%h want 1/5/1234", commit_valid, commit_rd, commit_val); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL alu_count_before got %0d want 1", count); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL alu_count_after got %0d want 0", count); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(3'd0, 5'(i + 1), 1'b0, 32'h0);
    checks++; if (count !== 3'd4 || alloc_ready !== 1'b0) begin errors++; $display("FAIL full got %0d/%0b want 4/0", count, alloc_ready); end
    alloc_valid = 1'b1; alloc_kind = 3'd0; alloc_rd = 5'd7;
    wb0(2'd0, 32'hAA);
    tick(); wb_valid = '0; #1;
    checks++; if (count !== 3'd4 || commit_valid !== 1'b1 || commit_idx !== 2'd0 || commit_val !== 32'hAA) begin errors++; $display("FAIL full_ignore got %0d/%0b/%0d/%h want 4/1/0/aa", count, commit_valid, commit_idx, commit_val); end
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_conservative got %0b want 0", alloc_ready); end
    tick(); alloc_valid = 1'b0; #1;
    checks++; if (count !== 3'd3 || alloc_ready !== 1'b1 || alloc_idx !== 2'd0 || commit_idx !== 2'd1) begin errors++; $display("FAIL wrap got %0d/%0b/%0d/%0d want 3/1/0/1", count, alloc_ready, alloc_idx, commit_idx); end
  endtask

  task automatic test_branch_mispredict();
    do_reset();
    alloc(3'd3, 5'd0, 1'b1, 32'h80);
    for (int i = 0; i < 3; i++) alloc(3'd0, 5'd4, 1'b0, 32'h0);
    wb_valid = 2'b10; wb_idx = 4'b0000; wb_val = {32'h0, 32'h0};
    tick(); wb_valid = '0; #1;
    checks++; if (commit_valid !== 1'b0 || redirect_valid !== 1'b0 || count !== 3'd4) begin errors++; $display("FAIL branch_retire got %0b/%0b/%0d want 0/0/4", commit_valid, redirect_valid, count); end
    tick();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80 || count !== 3'd0) begin errors++; $display("FAIL branch_redirect got %0b/%h/%0d want 1/80/0", redirect_valid, redirect_pc, count); end
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL pulse_alloc_ready got %0b want 0", alloc_ready); end
    alloc(3'd0, 5'd6, 1'b0, 32'h0);
    checks++; if (redirect_valid !== 1'b0 || count !== 3'd0 || alloc_idx !== 2'd0) begin errors++; $display("FAIL pulse_drop got %0b/%0d/%0d want 0/0/0", redirect_valid, count, alloc_idx); end
  endtask

  task automatic test_jalr();
    do_reset();
    alloc(3'd4, 5'd1, 1'b0, 32'h104);
    rs1_idx = 2'd0; wb0(2'd0, 32'h2000); #1;
    checks++; if (rs1_ready !== 1'b1 || rs1_val !== 32'h104) begin errors++; $display("FAIL jalr_lookup got %0b/%h want 1/104", rs1_ready, rs1_val); end
    tick(); wb_valid = '0; #1;
    checks++; if (commit_valid !== 1'b1 || commit_rd !== 5'd1 || commit_val !== 32'h104) begin errors++; $display("FAIL jalr_commit got %0b/%0d/%h want 1/1/104", commit_valid, commit_rd, commit_val); end
    tick();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2000 || count !== 3'd0) begin errors++; $display("FAIL jalr_redirect got %0b/%h/%0d want 1/2000/0", redirect_valid, redirect_pc, count); end
  endtask

  task automatic test_store_ack();
    do_reset();
    alloc(3'd2, 5'd0, 1'b0, 32'h0);
    alloc(3'd0, 5'd3, 1'b0, 32'h0);
    rs1_idx = 2'd0; #1;
    checks++; if (rs1_ready !== 1'b1 || rs1_val !== 32'h0) begin errors++; $display("FAIL store_lookup got %0b/%h want 1/0", rs1_ready, rs1_val); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (commit_store !== 1'b1 || commit_idx !== 2'd0 || count !== 3'd2) begin errors++; $display("FAIL store_wait%0d got %0b/%0d/%0d want 1/0/2", i, commit_store, commit_idx, count); end
      tick();
    end
    store_ack = 1'b1;
    tick(); store_ack = 1'b0; #1;
    checks++; if (commit_store !== 1'b0 || commit_idx !== 2'd1 || count !== 3'd1) begin errors++; $display("FAIL store_ack got %0b/%0d/%0d want 0/1/1", commit_store, commit_idx, count); end
  endtask

  task automatic test_stall();
    do_reset();
    alloc(3'd0, 5'd9, 1'b0, 32'h0);
    alloc(3'd0, 5'd10, 1'b0, 32'h0);
    wb0(2'd0, 32'h55); tick();
    rdy = 1'b0; wb0(2'd1, 32'h66); alloc_valid = 1'b1; #1;
    checks++; if (commit_valid !== 1'b0 || alloc_ready !== 1'b0) begin errors++; $display("FAIL stall_outputs got %0b/%0b want 0/0", commit_valid, alloc_ready); end
    tick(); tick();
    rdy = 1'b1; idle(); rs1_idx = 2'd1; #1;
    checks++; if (count !== 3'd2 || commit_valid !== 1'b1 || commit_val !== 32'h55) begin errors++; $display("FAIL stall_resume got %0d/%0b/%h want 2/1/55", count, commit_valid, commit_val); end
    checks++; if (rs1_ready !== 1'b0 || rs1_val !== 32'h1) begin errors++; $display("FAIL stall_wb_drop got %0b/%h want 0/1", rs1_ready, rs1_val); end
    tick();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL stall_retire got %0d want 1", count); end
  endtask

  task automatic test_reset_redirect();
    do_reset();
    alloc(3'd4, 5'd2, 1'b0, 32'h10);
    wb0(2'd0, 32'h300); tick(); wb_valid = '0;
    rst = 1'b0; tick(); rst = 1'b1; #1;
    checks++; if (redirect_valid !== 1'b0 || count !== 3'd0 || alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_over_redirect got %0b/%0d/%0b want 0/0/1", redirect_valid, count, alloc_ready); end
  endtask

  // Expected lookup for a tag from the model queue and this cycle's write-back strobes.
  function automatic void m_lookup(input int idx, output bit live, output bit r, output logic [31:0] v);
    int pos;
    bit found;
    ent_t e;
    pos = (idx - m_head + DEPTH) % DEPTH;
    live = (pos < q.size());
    r = 1'b0; v = 32'(idx); found = 1'b0;
    if (live) begin
      e = q[pos];
      if (e.kind == 3'd3 || e.kind == 3'd2) begin r = 1'b1; v = 32'h0; end
      else if (e.rdy) begin r = 1'b1; v = e.val; end
      else begin
        for (int p = 0; p < NUM_WB; p++) begin
          if (!found && rdy && wb_valid[p] && int'(wb_idx[p*IDX_W +: IDX_W]) == idx) begin
            found = 1'b1; r = 1'b1; v = (e.kind == 3'd4) ? e.val : wb_val[p*XLEN +: XLEN];
          end
        end
      end
    end
  endfunction

  task automatic test_random();
    int cnt, pos, sel;
    bit e_aready, e_cvalid, e_cstore, h_done, flush, live, er;
    logic [31:0] ev;
    bit done[DEPTH];
    ent_t h, t;
    do_reset();
    q.delete(); m_head = 0; m_redir = 1'b0; m_redir_pc = 32'h0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rdy = ($urandom_range(0, 7) != 0);
      alloc_valid = $urandom_range(0, 1);
      sel = $urandom_range(0, 11);
      alloc_kind = (sel < 4) ? 3'd0 : (sel < 6) ? 3'd1 : (sel < 8) ? 3'd2 : (sel < 10) ? 3'd3 : (sel == 10) ? 3'd4 : 3'd5;
      alloc_rd = 5'($urandom_range(0, 7));
      alloc_pred_taken = $urandom_range(0, 1);
      alloc_aux = $urandom;
      wb_valid = 2'($urandom_range(0, 3));
      wb_idx = 4'($urandom_range(0, 15));
      wb_val = {$urandom, $urandom};
      store_ack = $urandom_range(0, 1);
      rs1_idx = 2'($urandom_range(0, 3));
      rs2_idx = 2'($urandom_range(0, 3));
      #1;
      cnt = q.size();
      e_aready = rdy && cnt < DEPTH && !m_redir;
      h = (cnt > 0) ? q[0] : '0;
      h_done = rdy && cnt > 0 && ((h.kind == 3'd2) ? store_ack : h.rdy);
      e_cstore = rdy && cnt > 0 && h.kind == 3'd2;
      e_cvalid = h_done && h.kind != 3'd2 && h.kind != 3'd3 && h.rd != 5'd0;
      checks++; if (alloc_ready !== e_aready || alloc_idx !== 2'((m_head + cnt) % DEPTH)) begin errors++; $display("FAIL rnd_alloc c%0d got %0b/%0d want %0b/%0d", cyc, alloc_ready, alloc_idx, e_aready, (m_head + cnt) % DEPTH); end
      checks++; if (count !== 3'(cnt)) begin errors++; $display("FAIL rnd_count c%0d got %0d want %0d", cyc, count, cnt); end
      checks++; if (commit_valid !== e_cvalid || commit_store !== e_cstore) begin errors++; $display("FAIL rnd_commit c%0d got %0b/%0b want %0b/%0b", cyc, commit_valid, commit_store, e_cvalid, e_cstore); end
      if (e_cvalid) begin
        checks++; if (commit_rd !== h.rd || commit_val !== h.val || commit_idx !== 2'(m_head)) begin errors++; $display("FAIL rnd_commit_data c%0d got %0d/%h/%0d want %0d/%h/%0d", cyc, commit_rd, commit_val, commit_idx, h.rd, h.val, m_head); end
      end
      checks++; if (redirect_valid !== m_redir) begin errors++; $display("FAIL rnd_redirect c%0d got %0b want %0b", cyc, redirect_valid, m_redir); end
      if (m_redir) begin
        checks++; if (redirect_pc !== m_redir_pc) begin errors++; $display("FAIL rnd_redirect_pc c%0d got %h want %h", cyc, redirect_pc, m_redir_pc); end
      end
      m_lookup(int'(rs1_idx), live, er, ev);
      if (live) begin
        checks++; if (rs1_ready !== er || rs1_val !== ev) begin errors++; $display("FAIL rnd_rs1 c%0d got %0b/%h want %0b/%h", cyc, rs1_ready, rs1_val, er, ev); end
      end
      m_lookup(int'(rs2_idx), live, er, ev);
      if (live) begin
        checks++; if (rs2_ready !== er || rs2_val !== ev) begin errors++; $display("FAIL rnd_rs2 c%0d got %0b/%h want %0b/%h", cyc, rs2_ready, rs2_val, er, ev); end
      end
      // Advance the model by one clock edge.
      if (rdy) begin
        flush = h_done && ((h.kind == 3'd3 && h.taken != h.pred) || h.kind == 3'd4);
        m_redir = flush;
        if (flush) begin
          m_redir_pc = (h.kind == 3'd3) ? h.aux : h.tgt;
          q.delete(); m_head = 0;
        end else begin
          for (int i = 0; i < DEPTH; i++) done[i] = 1'b0;
          for (int p = 0; p < NUM_WB; p++) begin
            pos = (int'(wb_idx[p*IDX_W +: IDX_W]) - m_head + DEPTH) % DEPTH;
            if (wb_valid[p] && pos < cnt && !done[pos]) begin
              done[pos] = 1'b1;
              t = q[pos];
              t.rdy = 1'b1;
              if (t.kind == 3'd0 || t.kind == 3'd1) t.val = wb_val[p*XLEN +: XLEN];
              else if (t.kind == 3'd3) t.taken = wb_val[p*XLEN];
              else if (t.kind == 3'd4) t.tgt = wb_val[p*XLEN +: XLEN];
              q[pos] = t;
            end
          end
          if (h_done) begin void'(q.pop_front()); m_head = (m_head + 1) % DEPTH; end
          if (alloc_valid && e_aready) begin
            t = '0;
            t.kind = alloc_kind; t.rd = alloc_rd; t.pred = alloc_pred_taken; t.aux = alloc_aux;
            t.val = (alloc_kind == 3'd4 || alloc_kind == 3'd5) ? alloc_aux : 32'h0;
            t.rdy = (alloc_kind == 3'd2 || alloc_kind == 3'd5);
            q.push_back(t);
          end
        end
      end
      tick();
    end
    idle(); rdy = 1'b1;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; idle();
    test_reset();
    test_bypass_commit();
    test_full_wrap();
    test_branch_mispredict();
    test_jalr();
    test_store_ack();
    test_stall();
    test_reset_redirect();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
